// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared definitions for the load/store unit: ls_info bit positions,
// FSM state encoding and access-size byte masks.
package ysyx_22040237_lsu_pkg;

  localparam int LS_LOAD  = 0;
  localparam int LS_STORE = 1;
  localparam int LS_USIGN = 2;
  localparam int LS_BYTE  = 3;
  localparam int LS_HALF  = 4;
  localparam int LS_WORD  = 5;
  localparam int LS_DW    = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// Combinational LSU datapath: size decode, misalign check, store lane
// shift/mask and load extract with sign/zero extension.
module ysyx_22040237_lsu_align
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [4:0]      size_info_i,  // ls_info[6:2]: {dw, word, half, byte, usign}
  input  logic [2:0]      off_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [7:0]      wmask_o,
  output logic [XLEN-1:0] rdext_o,
  output logic            misalign_o
);

  lsu_size_e       size;
  logic [5:0]      sh_amt;
  logic [7:0]      size_mask;
  logic [XLEN-1:0] shifted;
  logic            usign;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input lsu_size_e sz,
                                             input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = v[7:0];
    h = v[15:0];
    w = v[31:0];
    case (sz)
      SZ_B:    extend = uns ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
      SZ_H:    extend = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      SZ_W:    extend = uns ? {{(XLEN-32){1'b0}}, w} : {{(XLEN-32){w[31]}}, w};
      default: extend = v;
    endcase
  endfunction

  // dw beats word beats half beats byte; no size bit means doubleword
  always_comb begin
    size = SZ_D;
    if (size_info_i[LS_DW-2])        size = SZ_D;
    else if (size_info_i[LS_WORD-2]) size = SZ_W;
    else if (size_info_i[LS_HALF-2]) size = SZ_H;
    else if (size_info_i[LS_BYTE-2]) size = SZ_B;
  end

  always_comb begin
    size_mask  = MASK_D;
    misalign_o = 1'b0;
    case (size)
      SZ_B: begin size_mask = MASK_B; misalign_o = 1'b0;        end
      SZ_H: begin size_mask = MASK_H; misalign_o = off_i[0];    end
      SZ_W: begin size_mask = MASK_W; misalign_o = |off_i[1:0]; end
      default: begin size_mask = MASK_D; misalign_o = |off_i;   end
    endcase
  end

  assign usign   = size_info_i[LS_USIGN-2];
  assign sh_amt  = {off_i, 3'b000};
  assign wdata_o = rs2_i << sh_amt;
  assign wmask_o = size_mask << off_i;
  assign shifted = rdata_i >> sh_amt;
  assign rdext_o = extend(shifted, size, usign);

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: one outstanding data-memory access, registered
// writeback slot, single-cycle pass-through for non-memory ops.
module ysyx_22040237_lsu
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic            rd_wr_en_i,
  input  logic [4:0]      rd_idx_i,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic [6:0]      ls_info_bus_i,
  input  logic [XLEN-1:0] rs2_store_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [7:0]      mem_wmask_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic            wb_rd_wr_en_o,
  output logic [4:0]      wb_rd_idx_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            misalign_o
);

  lsu_state_e      state_q, state_d;
  logic            req_q, req_d, we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [7:0]      wmask_q, wmask_d;
  logic [4:0]      info_q, info_d;
  logic [2:0]      off_q, off_d;
  logic            rd_wen_q, rd_wen_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic            wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d;
  logic [4:0]      wb_idx_q, wb_idx_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            mis_q, mis_d;

  logic            accept, is_ls, is_store;
  logic [4:0]      al_info;
  logic [2:0]      al_off;
  logic [XLEN-1:0] al_wdata, al_rdext;
  logic [7:0]      al_wmask;
  logic            al_mis;

  assign ex_ready_o = (state_q == ST_IDLE) && (!wb_valid_q || wb_ready_i);
  assign accept     = ex_valid_i && ex_ready_o;
  assign is_store   = ls_info_bus_i[LS_STORE];
  assign is_ls      = ls_info_bus_i[LS_LOAD] || is_store;

  // In IDLE the aligner sees the incoming op; otherwise the latched access
  assign al_info = (state_q == ST_IDLE) ? ls_info_bus_i[6:2] : info_q;
  assign al_off  = (state_q == ST_IDLE) ? alu_res_i[2:0]     : off_q;

  ysyx_22040237_lsu_align #(.XLEN(XLEN)) u_align (
    .size_info_i (al_info),
    .off_i       (al_off),
    .rs2_i       (rs2_store_i),
    .rdata_i     (mem_rdata_i),
    .wdata_o     (al_wdata),
    .wmask_o     (al_wmask),
    .rdext_o     (al_rdext),
    .misalign_o  (al_mis)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    info_d     = info_q;
    off_d      = off_q;
    rd_wen_d   = rd_wen_q;
    rd_idx_d   = rd_idx_q;
    wb_valid_d = wb_valid_q && !wb_ready_i;
    wb_wen_d   = wb_wen_q;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    mis_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_ls) begin
            wb_valid_d = 1'b1;
            wb_wen_d   = rd_wr_en_i;
            wb_idx_d   = rd_idx_i;
            wb_data_d  = alu_res_i;
          end else if (al_mis) begin
            mis_d      = 1'b1;
            wb_valid_d = 1'b1;
            wb_wen_d   = 1'b0;
            wb_idx_d   = rd_idx_i;
            wb_data_d  = '0;
          end else begin
            state_d  = ST_REQ;
            req_d    = 1'b1;
            we_d     = is_store;
            addr_d   = {alu_res_i[AW-1:3], 3'b000};
            wdata_d  = is_store ? al_wdata : '0;
            wmask_d  = is_store ? al_wmask : 8'h00;
            info_d   = ls_info_bus_i[6:2];
            off_d    = alu_res_i[2:0];
            rd_wen_d = rd_wr_en_i;
            rd_idx_d = rd_idx_i;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_wen_d   = 1'b0;
            wb_idx_d   = rd_idx_q;
          end else begin
            state_d = ST_WAIT_R;
          end
        end
      end
      ST_WAIT_R: begin
        if (mem_rvalid_i) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_wen_d   = rd_wen_q;
          wb_idx_d   = rd_idx_q;
          wb_data_d  = al_rdext;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= 8'h00;
      info_q     <= '0;
      off_q      <= '0;
      rd_wen_q   <= 1'b0;
      rd_idx_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      info_q     <= info_d;
      off_q      <= off_d;
      rd_wen_q   <= rd_wen_d;
      rd_idx_q   <= rd_idx_d;
      wb_valid_q <= wb_valid_d;
      wb_wen_q   <= wb_wen_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      mis_q      <= mis_d;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_wmask_o   = wmask_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_rd_wr_en_o = wb_wen_q;
  assign wb_rd_idx_o   = wb_idx_q;
  assign wb_data_o     = wb_data_q;
  assign misalign_o    = mis_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Directed bench for ysyx_22040237_lsu: vector table of single ops plus
// hand-written multi-cycle sequences (stalls, backpressure, reset).
module tb_ysyx_22040237_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_ready_o, rd_wr_en_i;
  logic [4:0]  rd_idx_i;
  logic [63:0] alu_res_i, rs2_store_i;
  logic [6:0]  ls_info_bus_i;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        wb_valid_o, wb_ready_i, wb_rd_wr_en_o;
  logic [4:0]  wb_rd_idx_o;
  logic [63:0] wb_data_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22040237_lsu dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i),
    .alu_res_i(alu_res_i), .ls_info_bus_i(ls_info_bus_i),
    .rs2_store_i(rs2_store_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_wr_en_o(wb_rd_wr_en_o), .wb_rd_idx_o(wb_rd_idx_o),
    .wb_data_o(wb_data_o), .misalign_o(misalign_o)
  );

  typedef struct {
    logic [6:0]  info;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic [63:0] rdata;
    logic [63:0] exp_data;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wdata;
    logic        exp_mis;
  } vec_t;

  localparam logic [63:0] R = 64'hFEDC_BA98_8765_4321;
  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [6:0] info, input logic [63:0] addr,
                          input logic [63:0] rs2, input logic [4:0] rd);
    ex_valid_i    = 1'b1;
    ls_info_bus_i = info;
    alu_res_i     = addr;
    rs2_store_i   = rs2;
    rd_idx_i      = rd;
    rd_wr_en_i    = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input logic [4:0] rd);
    logic is_ld, is_st;
    is_ld = v.info[0];
    is_st = v.info[1];
    drive_op(v.info, v.addr, v.rs2, rd);
    #1;
    chk("ex_ready_idle", {63'd0, ex_ready_o}, 64'd1);
    tick();
    ex_valid_i = 1'b0;
    if (v.exp_mis) begin
      chk("mis_pulse", {63'd0, misalign_o}, 64'd1);
      chk("mis_noreq", {63'd0, mem_req_o}, 64'd0);
      chk("mis_wbv",   {63'd0, wb_valid_o}, 64'd1);
      chk("mis_wen",   {63'd0, wb_rd_wr_en_o}, 64'd0);
      chk("mis_data",  wb_data_o, 64'd0);
    end else if (!is_ld && !is_st) begin
      chk("pt_wbv",  {63'd0, wb_valid_o}, 64'd1);
      chk("pt_data", wb_data_o, v.exp_data);
      chk("pt_idx",  {59'd0, wb_rd_idx_o}, {59'd0, rd});
      chk("pt_wen",  {63'd0, wb_rd_wr_en_o}, 64'd1);
    end else begin
      chk("req",   {63'd0, mem_req_o}, 64'd1);
      chk("addr",  mem_addr_o, {v.addr[63:3], 3'b000});
      chk("we",    {63'd0, mem_we_o}, {63'd0, is_st});
      chk("wmask", {56'd0, mem_wmask_o}, {56'd0, v.exp_mask});
      if (is_st) chk("wdata", mem_wdata_o, v.exp_wdata);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      chk("req_drop", {63'd0, mem_req_o}, 64'd0);
      if (is_ld) begin
        chk("ld_nowb_yet", {63'd0, wb_valid_o}, 64'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = v.rdata;
        tick();
        mem_rvalid_i = 1'b0;
        chk("ld_data", wb_data_o, v.exp_data);
        chk("ld_wen",  {63'd0, wb_rd_wr_en_o}, 64'd1);
      end else begin
        chk("st_wen", {63'd0, wb_rd_wr_en_o}, 64'd0);
      end
      chk("ls_wbv", {63'd0, wb_valid_o}, 64'd1);
      chk("ls_idx", {59'd0, wb_rd_idx_o}, {59'd0, rd});
    end
    tick();
    chk("drain", {63'd0, wb_valid_o}, 64'd0);
    chk("mis_clear", {63'd0, misalign_o}, 64'd0);
  endtask

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{7'h00, 64'h1234,        64'd0, 64'd0, 64'h1234,                 8'h00, 64'd0, 1'b0};
    vecs[1]  = '{7'h09, 64'h8000_0003,   64'd0, B,     64'hFFFF_FFFF_FFFF_FF80,  8'h00, 64'd0, 1'b0};
    vecs[2]  = '{7'h0D, 64'h8000_0003,   64'd0, B,     64'h80,                   8'h00, 64'd0, 1'b0};
    vecs[3]  = '{7'h11, 64'h8000_0004,   64'd0, R,     64'hFFFF_FFFF_FFFF_BA98,  8'h00, 64'd0, 1'b0};
    vecs[4]  = '{7'h15, 64'h8000_0002,   64'd0, R,     64'h8765,                 8'h00, 64'd0, 1'b0};
    vecs[5]  = '{7'h21, 64'h8000_0004,   64'd0, R,     64'hFFFF_FFFF_FEDC_BA98,  8'h00, 64'd0, 1'b0};
    vecs[6]  = '{7'h25, 64'h8000_0000,   64'd0, R,     64'h8765_4321,            8'h00, 64'd0, 1'b0};
    vecs[7]  = '{7'h21, 64'h8000_0000,   64'd0, R,     64'hFFFF_FFFF_8765_4321,  8'h00, 64'd0, 1'b0};
    vecs[8]  = '{7'h41, 64'h8000_0008,   64'd0, R,     R,                        8'h00, 64'd0, 1'b0};
    vecs[9]  = '{7'h01, 64'h8000_0010,   64'd0, R,     R,                        8'h00, 64'd0, 1'b0};
    vecs[10] = '{7'h09, 64'h8000_0007,   64'd0, R,     64'hFFFF_FFFF_FFFF_FFFE,  8'h00, 64'd0, 1'b0};
    vecs[11] = '{7'h0A, 64'h8000_0005,   64'hAB, 64'd0, 64'd0, 8'h20, 64'h0000_AB00_0000_0000, 1'b0};
    vecs[12] = '{7'h12, 64'h8000_0006,   64'hABCD, 64'd0, 64'd0, 8'hC0, 64'hABCD_0000_0000_0000, 1'b0};
    vecs[13] = '{7'h22, 64'h8000_0004,   64'h1234_5678, 64'd0, 64'd0, 8'hF0, 64'h1234_5678_0000_0000, 1'b0};
    vecs[14] = '{7'h42, 64'h8000_0010,   64'h0123_4567_89AB_CDEF, 64'd0, 64'd0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[15] = '{7'h21, 64'h8000_0002,   64'd0, R, 64'd0, 8'h00, 64'd0, 1'b1};
    vecs[16] = '{7'h41, 64'h8000_0004,   64'd0, R, 64'd0, 8'h00, 64'd0, 1'b1};
    vecs[17] = '{7'h12, 64'h8000_0001,   64'hABCD, 64'd0, 64'd0, 8'h00, 64'd0, 1'b1};
    vecs[18] = '{7'h22, 64'h8000_0006,   64'h1, 64'd0, 64'd0, 8'h00, 64'd0, 1'b1};

    rst = 1'b1; ex_valid_i = 1'b0; rd_wr_en_i = 1'b0; rd_idx_i = '0;
    alu_res_i = '0; ls_info_bus_i = '0; rs2_store_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; wb_ready_i = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req",   {63'd0, mem_req_o}, 64'd0);
    chk("rst_wbv",   {63'd0, wb_valid_o}, 64'd0);
    chk("rst_mis",   {63'd0, misalign_o}, 64'd0);
    chk("rst_addr",  mem_addr_o, 64'd0);
    chk("rst_wdata", wb_data_o, 64'd0);
    chk("rst_ready", {63'd0, ex_ready_o}, 64'd1);

    for (int i = 0; i < 19; i++) run_vec(vecs[i], 5'(i + 1));

    // back-to-back pass-through ops at one per cycle
    drive_op(7'h00, 64'h1234, 64'd0, 5'd5);
    tick();
    chk("b2b0_data", wb_data_o, 64'h1234);
    chk("b2b0_idx", {59'd0, wb_rd_idx_o}, 64'd5);
    drive_op(7'h00, 64'h5678, 64'd0, 5'd6);
    #1 chk("b2b_ready", {63'd0, ex_ready_o}, 64'd1);
    tick();
    chk("b2b1_data", wb_data_o, 64'h5678);
    drive_op(7'h00, 64'h9ABC, 64'd0, 5'd7);
    tick();
    chk("b2b2_data", wb_data_o, 64'h9ABC);
    chk("b2b2_wbv", {63'd0, wb_valid_o}, 64'd1);
    ex_valid_i = 1'b0;
    tick();
    chk("b2b_drain", {63'd0, wb_valid_o}, 64'd0);

    // sh with grant delayed three cycles: request held stable
    drive_op(7'h12, 64'h8000_0006, 64'hABCD, 5'd9);
    tick();
    ex_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("sh_hold_req", {63'd0, mem_req_o}, 64'd1);
      chk("sh_hold_addr", mem_addr_o, 64'h8000_0000);
      chk("sh_hold_mask", {56'd0, mem_wmask_o}, 64'hC0);
      chk("sh_hold_wdata", {48'd0, mem_wdata_o[63:48]}, 64'hABCD);
      chk("sh_hold_ready", {63'd0, ex_ready_o}, 64'd0);
      tick();
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("sh_req_drop", {63'd0, mem_req_o}, 64'd0);
    chk("sh_wbv", {63'd0, wb_valid_o}, 64'd1);
    chk("sh_wen", {63'd0, wb_rd_wr_en_o}, 64'd0);
    tick();

    // ld under writeback backpressure; gnt+rvalid together count as gnt only
    wb_ready_i = 1'b0;
    drive_op(7'h41, 64'h8000_0018, 64'd0, 5'd12);
    tick();
    ex_valid_i = 1'b0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_0000_0001;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    chk("gntrv_nowb", {63'd0, wb_valid_o}, 64'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = R;
    tick();
    mem_rvalid_i = 1'b0;
    chk("bp_data", wb_data_o, R);
    for (int k = 0; k < 2; k++) begin
      chk("bp_hold_wbv", {63'd0, wb_valid_o}, 64'd1);
      chk("bp_hold_ready", {63'd0, ex_ready_o}, 64'd0);
      tick();
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
    tick();
    mem_rvalid_i = 1'b0;
    chk("spur_rv_data", wb_data_o, R);
    wb_ready_i = 1'b1;
    #1 chk("bp_release_ready", {63'd0, ex_ready_o}, 64'd1);
    tick();
    chk("bp_drain", {63'd0, wb_valid_o}, 64'd0);

    // reset while waiting for read data, then a stale rvalid
    drive_op(7'h41, 64'h8000_0020, 64'd0, 5'd3);
    tick();
    ex_valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = R;
    tick();
    mem_rvalid_i = 1'b0;
    chk("rstw_wbv",   {63'd0, wb_valid_o}, 64'd0);
    chk("rstw_req",   {63'd0, mem_req_o}, 64'd0);
    chk("rstw_addr",  mem_addr_o, 64'd0);
    chk("rstw_data",  wb_data_o, 64'd0);
    chk("rstw_ready", {63'd0, ex_ready_o}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
